// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data-stage and memory-side signal bundle for the
//               memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 7
);
    logic          i_req;
    logic [31:0]   i_addr;
    logic [31:0]   i_rdata;
    logic          i_ack;

    logic          d_rd;
    logic          d_wr;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ack;

    logic          stall_if;
    logic          stall_mem;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
        output m_en, m_we, m_addr, m_wdata
    );

    // Pipeline and memory view
    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between an instruction fetch
//               port and a data-stage load/store port. IDLE/BUSY/DONE FSM,
//               fixed LAT-cycle access. Define MEM_ARB_RR_EN for round-robin
//               arbitration; otherwise the data port has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW  = 7,
    parameter int LAT = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [2:0] c_LAT = 3'(LAT);
    localparam logic [2:0] c_ONE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_nxt;

    logic          r_gnt_data;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_i_pend;
    logic          w_d_pend;
    logic          w_sel_data;
    logic          w_grant;
    logic          w_capture;
    logic          w_m_en;
    logic          w_m_we;
    logic [AW-1:0] w_m_addr;
    logic [31:0]   w_m_wdata;
    logic          w_i_ack;
    logic          w_d_ack;

`ifdef MEM_ARB_RR_EN
    logic          r_last_data;
`endif

    assign w_i_pend = bus.i_req;
    assign w_d_pend = bus.d_rd | bus.d_wr;

    // Winner selection; only consulted when a grant is issued from IDLE
    always_comb begin
        w_sel_data = 1'b0;
`ifdef MEM_ARB_RR_EN
        w_sel_data = w_d_pend & (~w_i_pend | ~r_last_data);
`else
        w_sel_data = w_d_pend;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_m_en      = 1'b0;
        w_m_we      = 1'b0;
        w_m_addr    = '0;
        w_m_wdata   = '0;
        w_i_ack     = 1'b0;
        w_d_ack     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_i_pend | w_d_pend) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = c_LAT;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Counter still at LAT marks the first BUSY cycle
                w_m_en    = (r_cnt == c_LAT);
                w_m_we    = r_we;
                w_m_addr  = r_addr;
                w_m_wdata = r_wdata;
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_i_ack     = ~r_gnt_data;
                w_d_ack     = r_gnt_data;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_data <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_data <= w_sel_data;
                r_we       <= w_sel_data & bus.d_wr;
                r_addr     <= w_sel_data ? bus.d_addr[AW+1:2] : bus.i_addr[AW+1:2];
                r_wdata    <= w_sel_data ? bus.d_wdata : 32'd0;
            end
            // Writes leave both read-data registers untouched
            if (w_capture && !r_we) begin
                if (r_gnt_data) begin
                    r_d_rdata <= bus.m_rdata;
                end else begin
                    r_i_rdata <= bus.m_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (w_grant) begin
            r_last_data <= w_sel_data;
        end
    end
`endif

    assign bus.m_en      = w_m_en;
    assign bus.m_we      = w_m_we;
    assign bus.m_addr    = w_m_addr;
    assign bus.m_wdata   = w_m_wdata;
    assign bus.i_ack     = w_i_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.stall_if  = bus.i_req & ~w_i_ack;
    assign bus.stall_mem = w_d_pend & ~w_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench; LAT=2 and LAT=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.AW(7)) bus2 ();
    mem_port_arbiter_if #(.AW(7)) bus1 ();

    mem_port_arbiter #(.AW(7), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_port_arbiter #(.AW(7), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_cycle();
        rst = 1'b1;
        start_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus2.i_ack, bus2.d_ack, bus2.m_en, bus2.m_we, bus2.m_addr, bus2.m_wdata,
             bus2.i_rdata, bus2.d_rdata, bus2.stall_if, bus2.stall_mem} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut2: ack=%b%b en=%b we=%b addr=%h wd=%h ird=%h drd=%h, want all 0",
                     bus2.i_ack, bus2.d_ack, bus2.m_en, bus2.m_we, bus2.m_addr, bus2.m_wdata,
                     bus2.i_rdata, bus2.d_rdata);
        end
        n_checks++;
        if ({bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.m_addr, bus1.m_wdata,
             bus1.i_rdata, bus1.d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: outputs not all 0");
        end
        start_cycle();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        bus2.m_rdata = 32'h8C010004;
        bus2.i_addr  = 32'h10;
        bus2.i_req   = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.m_en !== (c == 1)) begin
                n_fail++; $display("FAIL fetch_m_en c%0d: got %b want %b", c, bus2.m_en, (c == 1));
            end
            n_checks++;
            if (bus2.m_addr !== ((c == 1 || c == 2) ? 7'd4 : 7'd0)) begin
                n_fail++; $display("FAIL fetch_m_addr c%0d: got %h", c, bus2.m_addr);
            end
            n_checks++;
            if (bus2.i_ack !== (c == 3)) begin
                n_fail++; $display("FAIL fetch_i_ack c%0d: got %b want %b", c, bus2.i_ack, (c == 3));
            end
            n_checks++;
            if (bus2.stall_if !== (c <= 2)) begin
                n_fail++; $display("FAIL fetch_stall_if c%0d: got %b want %b", c, bus2.stall_if, (c <= 2));
            end
            start_cycle();
            if (c == 3) bus2.i_req = 1'b0;
        end
        n_checks++;
        if (bus2.i_rdata !== 32'h8C010004) begin
            n_fail++; $display("FAIL fetch_i_rdata: got %h want 8c010004", bus2.i_rdata);
        end
    endtask

    task automatic test_write();
        bus2.d_addr  = 32'h20;
        bus2.d_wdata = 32'hDEADBEEF;
        bus2.d_wr    = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.m_we !== (c == 1 || c == 2)) begin
                n_fail++; $display("FAIL write_m_we c%0d: got %b", c, bus2.m_we);
            end
            n_checks++;
            if (bus2.m_addr !== ((c == 1 || c == 2) ? 7'd8 : 7'd0)) begin
                n_fail++; $display("FAIL write_m_addr c%0d: got %h", c, bus2.m_addr);
            end
            n_checks++;
            if (bus2.m_wdata !== ((c == 1 || c == 2) ? 32'hDEADBEEF : 32'h0)) begin
                n_fail++; $display("FAIL write_m_wdata c%0d: got %h", c, bus2.m_wdata);
            end
            n_checks++;
            if (bus2.d_ack !== (c == 3)) begin
                n_fail++; $display("FAIL write_d_ack c%0d: got %b want %b", c, bus2.d_ack, (c == 3));
            end
            n_checks++;
            if (bus2.stall_mem !== (c <= 2)) begin
                n_fail++; $display("FAIL write_stall_mem c%0d: got %b", c, bus2.stall_mem);
            end
            start_cycle();
            if (c == 3) bus2.d_wr = 1'b0;
        end
        n_checks++;
        if (bus2.d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL write_d_rdata: got %h want 00000000", bus2.d_rdata);
        end
    endtask

    task automatic test_contention_continuous();
        logic exp_d;
        logic exp_i;
        do_reset();
        bus2.m_rdata = 32'h11112222;
        bus2.i_addr  = 32'h40;
        bus2.d_addr  = 32'h80;
        bus2.i_req   = 1'b1;
        bus2.d_rd    = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            exp_d = (c == 3) || (c == 11) || (c == 7 && !c_RR);
            exp_i = (c == 7) && c_RR;
            n_checks++;
            if (bus2.d_ack !== exp_d) begin
                n_fail++; $display("FAIL cont_d_ack c%0d: got %b want %b", c, bus2.d_ack, exp_d);
            end
            n_checks++;
            if (bus2.i_ack !== exp_i) begin
                n_fail++; $display("FAIL cont_i_ack c%0d: got %b want %b", c, bus2.i_ack, exp_i);
            end
            if (c == 5) begin
                n_checks++;
                if (bus2.m_addr !== (c_RR ? 7'h10 : 7'h20)) begin
                    n_fail++; $display("FAIL cont_m_addr c5: got %h", bus2.m_addr);
                end
            end
            start_cycle();
        end
        n_checks++;
        if (bus2.i_rdata !== (c_RR ? 32'h11112222 : 32'h0)) begin
            n_fail++; $display("FAIL cont_i_rdata: got %h", bus2.i_rdata);
        end
        bus2.i_req = 1'b0;
        bus2.d_rd  = 1'b0;
    endtask

    task automatic test_contention_release();
        do_reset();
        bus2.m_rdata = 32'h33334444;
        bus2.i_addr  = 32'h40;
        bus2.d_addr  = 32'h80;
        bus2.i_req   = 1'b1;
        bus2.d_rd    = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.d_ack !== (c == 3)) begin
                n_fail++; $display("FAIL rel_d_ack c%0d: got %b want %b", c, bus2.d_ack, (c == 3));
            end
            n_checks++;
            if (bus2.i_ack !== (c == 7)) begin
                n_fail++; $display("FAIL rel_i_ack c%0d: got %b want %b", c, bus2.i_ack, (c == 7));
            end
            start_cycle();
            if (c == 3) bus2.d_rd  = 1'b0;
            if (c == 7) bus2.i_req = 1'b0;
        end
        n_checks++;
        if (bus2.d_rdata !== 32'h33334444 || bus2.i_rdata !== 32'h33334444) begin
            n_fail++; $display("FAIL rel_rdata: got d=%h i=%h want 33334444", bus2.d_rdata, bus2.i_rdata);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        bus2.m_rdata = 32'h55556666;
        bus2.i_addr  = 32'h10;
        bus2.i_req   = 1'b1;
        start_cycle();
        @(negedge clk);
        n_checks++;
        if (bus2.m_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_m_en c1: got %b want 1", bus2.m_en);
        end
        start_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus2.i_ack, bus2.d_ack, bus2.m_en, bus2.m_we, bus2.m_addr, bus2.m_wdata,
             bus2.i_rdata, bus2.d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: en=%b addr=%h ack=%b ird=%h, want all 0",
                     bus2.m_en, bus2.m_addr, bus2.i_ack, bus2.i_rdata);
        end
        bus2.i_req = 1'b0;
        start_cycle();
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.i_ack !== 1'b0 || bus2.m_en !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_lost k%0d: ack=%b en=%b want 0", k, bus2.i_ack, bus2.m_en);
            end
            start_cycle();
        end
        bus2.i_req = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.i_ack !== (c == 3)) begin
                n_fail++; $display("FAIL rstmid_retry_ack c%0d: got %b want %b", c, bus2.i_ack, (c == 3));
            end
            start_cycle();
            if (c == 3) bus2.i_req = 1'b0;
        end
        n_checks++;
        if (bus2.i_rdata !== 32'h55556666) begin
            n_fail++; $display("FAIL rstmid_i_rdata: got %h want 55556666", bus2.i_rdata);
        end
    endtask

    task automatic test_drop_req();
        bus2.m_rdata = 32'hCAFEF00D;
        bus2.i_addr  = 32'h24;
        bus2.i_req   = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.m_addr !== ((c == 1 || c == 2) ? 7'd9 : 7'd0)) begin
                n_fail++; $display("FAIL drop_m_addr c%0d: got %h", c, bus2.m_addr);
            end
            n_checks++;
            if (bus2.i_ack !== (c == 3)) begin
                n_fail++; $display("FAIL drop_i_ack c%0d: got %b want %b", c, bus2.i_ack, (c == 3));
            end
            start_cycle();
            if (c == 0) bus2.i_req = 1'b0;
        end
        n_checks++;
        if (bus2.i_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL drop_i_rdata: got %h want cafef00d", bus2.i_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        bus1.m_rdata = 32'h0BADF00D;
        bus1.d_addr  = 32'hFFFFFF0F;
        bus1.d_rd    = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            exp_ack = (c == 2) || (c == 5) || (c == 8);
            n_checks++;
            if (bus1.d_ack !== exp_ack) begin
                n_fail++; $display("FAIL b2b_d_ack c%0d: got %b want %b", c, bus1.d_ack, exp_ack);
            end
            n_checks++;
            if (bus1.stall_mem !== (c <= 8 && !exp_ack)) begin
                n_fail++; $display("FAIL b2b_stall_mem c%0d: got %b", c, bus1.stall_mem);
            end
            if (c == 1) begin
                n_checks++;
                if (bus1.m_en !== 1'b1 || bus1.m_addr !== 7'h43) begin
                    n_fail++; $display("FAIL b2b_m_addr c1: en=%b addr=%h want en=1 addr=43", bus1.m_en, bus1.m_addr);
                end
            end
            start_cycle();
            if (c == 8) bus1.d_rd = 1'b0;
        end
        n_checks++;
        if (bus1.d_rdata !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL b2b_d_rdata: got %h want 0badf00d", bus1.d_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_rd = 1'b0; bus2.d_wr = 1'b0;
        bus2.d_addr = '0;  bus2.d_wdata = '0; bus2.m_rdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_rd = 1'b0; bus1.d_wr = 1'b0;
        bus1.d_addr = '0;  bus1.d_wdata = '0; bus1.m_rdata = '0;

        test_reset();
        test_fetch();
        test_write();
        test_contention_continuous();
        test_contention_release();
        test_reset_mid_busy();
        test_drop_req();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
